// File: rtl/matrix_mult_pkg.sv
// Shared types and constants for the 2x2 16.16 matrix multiplier
// and its stream-side sequencer.
package matrix_mult_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } mm_state_e;

    localparam logic [2:0] IDX_A11 = 3'd0;
    localparam logic [2:0] IDX_A12 = 3'd1;
    localparam logic [2:0] IDX_A21 = 3'd2;
    localparam logic [2:0] IDX_A22 = 3'd3;
    localparam logic [2:0] IDX_B11 = 3'd4;
    localparam logic [2:0] IDX_B12 = 3'd5;
    localparam logic [2:0] IDX_B21 = 3'd6;
    localparam logic [2:0] IDX_B22 = 3'd7;

    localparam logic [1:0] IDX_C11 = 2'd0;
    localparam logic [1:0] IDX_C12 = 2'd1;
    localparam logic [1:0] IDX_C21 = 2'd2;
    localparam logic [1:0] IDX_C22 = 2'd3;

endpackage

// File: rtl/matrix_mult_stream_if.sv
// Stream sequencer: gathers eight operand words, starts matrix_mult,
// captures its four results and drains them downstream.
module matrix_mult_stream_if #(
    parameter int DATA_W         = matrix_mult_pkg::DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] mm_a11,
    output logic [DATA_W-1:0] mm_a12,
    output logic [DATA_W-1:0] mm_a21,
    output logic [DATA_W-1:0] mm_a22,
    output logic [DATA_W-1:0] mm_b11,
    output logic [DATA_W-1:0] mm_b12,
    output logic [DATA_W-1:0] mm_b21,
    output logic [DATA_W-1:0] mm_b22,
    output logic              mm_start,
    input  logic [DATA_W-1:0] mm_c11,
    input  logic [DATA_W-1:0] mm_c12,
    input  logic [DATA_W-1:0] mm_c21,
    input  logic [DATA_W-1:0] mm_c22,
    input  logic              mm_done,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              timeout_err
);

    import matrix_mult_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    mm_state_e                state_q, state_d;
    logic [2:0]               widx_q, widx_d;
    logic [1:0]               oidx_q, oidx_d;
    logic [1:0]               oidx_n;
    logic [CNT_W-1:0]         wcnt_q, wcnt_d;
    logic [7:0][DATA_W-1:0]   ops_q, ops_d;
    logic [3:0][DATA_W-1:0]   res_q, res_d;
    logic [DATA_W-1:0]        mdata_q, mdata_d;
    logic                     mlast_q, mlast_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            widx_q  <= '0;
            oidx_q  <= '0;
            wcnt_q  <= '0;
            ops_q   <= '0;
            res_q   <= '0;
            mdata_q <= '0;
            mlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            oidx_q  <= oidx_d;
            wcnt_q  <= wcnt_d;
            ops_q   <= ops_d;
            res_q   <= res_d;
            mdata_q <= mdata_d;
            mlast_q <= mlast_d;
        end
    end

    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        oidx_d  = oidx_q;
        wcnt_d  = wcnt_q;
        ops_d   = ops_q;
        res_d   = res_q;
        mdata_d = mdata_q;
        mlast_d = mlast_q;
        oidx_n  = oidx_q + 2'd1;
        unique case (state_q)
            LOAD: begin
                if (s_valid) begin
                    ops_d[widx_q] = s_data;
                    widx_d = widx_q + 3'd1;
                    if (widx_q == IDX_B22) state_d = START;
                end
            end
            START: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done takes priority over an expiring counter
                if (mm_done) begin
                    res_d[IDX_C11] = mm_c11;
                    res_d[IDX_C12] = mm_c12;
                    res_d[IDX_C21] = mm_c21;
                    res_d[IDX_C22] = mm_c22;
                    mdata_d = mm_c11;
                    mlast_d = 1'b0;
                    oidx_d  = IDX_C11;
                    state_d = DRAIN;
                end else if (wcnt_q == CNT_MAX) begin
                    state_d = LOAD;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (m_ready) begin
                    if (oidx_q == IDX_C22) begin
                        oidx_d  = '0;
                        mdata_d = '0;
                        mlast_d = 1'b0;
                        state_d = LOAD;
                    end else begin
                        oidx_d  = oidx_n;
                        mdata_d = res_q[oidx_n];
                        mlast_d = (oidx_n == IDX_C22);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign s_ready     = (state_q == LOAD);
    assign mm_start    = (state_q == START);
    assign m_valid     = (state_q == DRAIN);
    assign busy        = (state_q != LOAD);
    assign timeout_err = (state_q == WAIT) && !mm_done && (wcnt_q == CNT_MAX);
    assign m_data      = mdata_q;
    assign m_last      = mlast_q;

    assign mm_a11 = ops_q[IDX_A11];
    assign mm_a12 = ops_q[IDX_A12];
    assign mm_a21 = ops_q[IDX_A21];
    assign mm_a22 = ops_q[IDX_A22];
    assign mm_b11 = ops_q[IDX_B11];
    assign mm_b12 = ops_q[IDX_B12];
    assign mm_b21 = ops_q[IDX_B21];
    assign mm_b22 = ops_q[IDX_B22];

endmodule

// File: tb/tb_matrix_mult_stream_if.sv
// Directed bench for matrix_mult_stream_if with a behavioural
// 16.16 multiplier stub whose done timing can be steered.
module tb_matrix_mult_stream_if;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [31:0] mm_a11, mm_a12, mm_a21, mm_a22;
    logic [31:0] mm_b11, mm_b12, mm_b21, mm_b22;
    logic        mm_start;
    logic [31:0] mm_c11, mm_c12, mm_c21, mm_c22;
    logic        mm_done;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b1;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    int   mode = 0;
    int   lat = 3;
    logic garbage = 1'b0;
    logic stray = 1'b0;
    int   dcnt;

    logic [7:0][31:0] d1, d2, d3;
    logic [3:0][31:0] e1, e2, e3;

    always #5 clk = ~clk;

    matrix_mult_stream_if #(.DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mm_a11(mm_a11), .mm_a12(mm_a12), .mm_a21(mm_a21), .mm_a22(mm_a22),
        .mm_b11(mm_b11), .mm_b12(mm_b12), .mm_b21(mm_b21), .mm_b22(mm_b22),
        .mm_start(mm_start),
        .mm_c11(mm_c11), .mm_c12(mm_c12), .mm_c21(mm_c21), .mm_c22(mm_c22),
        .mm_done(mm_done),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [31:0] fx(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p[47:16];
    endfunction

    assign mm_c11 = garbage ? 32'hDEADBEEF : fx(mm_a11, mm_b11) + fx(mm_a12, mm_b21);
    assign mm_c12 = garbage ? 32'hDEADBEEF : fx(mm_a11, mm_b12) + fx(mm_a12, mm_b22);
    assign mm_c21 = garbage ? 32'hDEADBEEF : fx(mm_a21, mm_b11) + fx(mm_a22, mm_b21);
    assign mm_c22 = garbage ? 32'hDEADBEEF : fx(mm_a21, mm_b12) + fx(mm_a22, mm_b22);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt <= 0;
        else if (mm_start) dcnt <= 1;
        else if (dcnt != 0 && dcnt < 200) dcnt <= dcnt + 1;
        else dcnt <= 0;
    end

    assign mm_done = stray || (mode == 0 && dcnt == lat);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic load_words(input logic [7:0][31:0] d, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) tick();
            send(d[i]);
        end
    endtask

    task automatic collect(output logic [3:0][31:0] w, output logic [3:0] l, output bit to);
        int n;
        m_ready = 1'b1;
        to = 1'b0;
        w = '0;
        l = '0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!m_valid && n < 300) begin
                tick();
                n++;
            end
            if (!m_valid) begin
                to = 1'b1;
                break;
            end
            w[i] = m_data;
            l[i] = m_last;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 32'h0) begin
            errors++; $display("FAIL reset_out got v=%b l=%b d=%h want 0 0 0", m_valid, m_last, m_data);
        end
        checks++;
        if (mm_start !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_ctl got st=%b busy=%b te=%b want 0 0 0", mm_start, busy, timeout_err);
        end
        checks++;
        if (mm_a11 !== 32'h0 || mm_b22 !== 32'h0) begin
            errors++; $display("FAIL reset_ops got %h %h want 0 0", mm_a11, mm_b22);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nominal();
        logic [3:0][31:0] w;
        logic [3:0] l;
        bit to;
        load_words(d1, 8, 1'b0);
        checks++;
        if (mm_start !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL nom_start got st=%b rdy=%b busy=%b want 1 0 1", mm_start, s_ready, busy);
        end
        checks++;
        if (mm_a12 !== 32'h00020000 || mm_b22 !== 32'h00080000) begin
            errors++; $display("FAIL nom_ops got %h %h want 00020000 00080000", mm_a12, mm_b22);
        end
        tick();
        checks++;
        if (mm_start !== 1'b0) begin errors++; $display("FAIL nom_start_pulse got %b want 0", mm_start); end
        collect(w, l, to);
        checks++;
        if (to) begin errors++; $display("FAIL nom_timeout got stalled want 4 words"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w[i] !== e1[i] || l[i] !== (i == 3)) begin
                errors++; $display("FAIL nom_word%0d got %h last=%b want %h last=%b", i, w[i], l[i], e1[i], (i == 3));
            end
        end
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL nom_end got v=%b rdy=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold;
        int n;
        bit ok;
        load_words(d2, 8, 1'b1);
        checks++;
        if (mm_a21 !== 32'hFFFF0000 || mm_b12 !== 32'h00010000) begin
            errors++; $display("FAIL bp_ops got %h %h want ffff0000 00010000", mm_a21, mm_b12);
        end
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!m_valid && n < 300) begin
                tick();
                n++;
            end
            hold = m_data;
            ok = m_valid;
            repeat (5) begin
                tick();
                if (m_valid !== 1'b1 || m_data !== hold) ok = 1'b0;
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h want 1 %h", i, m_valid, m_data, hold); end
            checks++;
            if (hold !== e2[i] || m_last !== (i == 3)) begin
                errors++; $display("FAIL bp_word%0d got %h last=%b want %h last=%b", i, hold, m_last, e2[i], (i == 3));
            end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
        end
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL bp_end got v=%b rdy=%b want 0 1", m_valid, s_ready);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_timeout();
        logic [3:0][31:0] w;
        logic [3:0] l;
        bit to;
        bit mv;
        int n;
        mode = 1;
        load_words(d1, 8, 1'b0);
        n = 0;
        mv = 1'b0;
        while (!timeout_err && n < 200) begin
            tick();
            n++;
            if (m_valid) mv = 1'b1;
        end
        checks++;
        if (n !== T) begin errors++; $display("FAIL to_latency got %0d want %0d", n, T); end
        checks++;
        if (mv !== 1'b0) begin errors++; $display("FAIL to_no_valid got %b want 0", mv); end
        tick();
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_after got rdy=%b busy=%b te=%b want 1 0 0", s_ready, busy, timeout_err);
        end
        mode = 0;
        load_words(d1, 8, 1'b0);
        collect(w, l, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (to || w[i] !== e1[i] || l[i] !== (i == 3)) begin
                errors++; $display("FAIL to_next%0d got %h to=%b want %h", i, w[i], to, e1[i]);
            end
        end
    endtask

    task automatic test_boundary();
        logic [3:0][31:0] w;
        logic [3:0] l;
        bit to;
        bit te;
        int n;
        lat = T;
        load_words(d2, 8, 1'b0);
        n = 0;
        te = 1'b0;
        while (!m_valid && n < 200) begin
            if (timeout_err) te = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (te !== 1'b0) begin errors++; $display("FAIL bnd_err got %b want 0", te); end
        checks++;
        if (n !== T + 1) begin errors++; $display("FAIL bnd_latency got %0d want %0d", n, T + 1); end
        collect(w, l, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (to || w[i] !== e2[i] || l[i] !== (i == 3)) begin
                errors++; $display("FAIL bnd_word%0d got %h to=%b want %h", i, w[i], to, e2[i]);
            end
        end
        lat = 3;
    endtask

    task automatic test_reset_mid();
        logic [3:0][31:0] w;
        logic [3:0] l;
        bit to;
        int n;
        load_words(d1, 5, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0 || mm_a11 !== 32'h0 || mm_b11 !== 32'h0) begin
            errors++; $display("FAIL rst_load got rdy=%b busy=%b a11=%h b11=%h want 1 0 0 0", s_ready, busy, mm_a11, mm_b11);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        load_words(d3, 8, 1'b0);
        collect(w, l, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (to || w[i] !== e3[i] || l[i] !== (i == 3)) begin
                errors++; $display("FAIL rst_fresh%0d got %h to=%b want %h", i, w[i], to, e3[i]);
            end
        end
        load_words(d1, 8, 1'b0);
        n = 0;
        while (!m_valid && n < 300) begin
            tick();
            n++;
        end
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || m_last !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL rst_drain got v=%b d=%h l=%b rdy=%b want 0 0 0 1", m_valid, m_data, m_last, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        load_words(d2, 8, 1'b0);
        collect(w, l, to);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (to || w[i] !== e2[i] || l[i] !== (i == 3)) begin
                errors++; $display("FAIL rst_after%0d got %h to=%b want %h", i, w[i], to, e2[i]);
            end
        end
    endtask

    task automatic test_stray_done();
        int n;
        stray = 1'b1;
        garbage = 1'b1;
        tick();
        stray = 1'b0;
        garbage = 1'b0;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL stray_load got busy=%b rdy=%b want 0 1", busy, s_ready);
        end
        load_words(d3, 8, 1'b0);
        n = 0;
        while (!m_valid && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (m_data !== e3[0]) begin errors++; $display("FAIL stray_w0 got %h want %h", m_data, e3[0]); end
        tick();
        m_ready = 1'b0;
        stray = 1'b1;
        garbage = 1'b1;
        tick();
        stray = 1'b0;
        garbage = 1'b0;
        m_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== e3[i] || m_last !== (i == 3)) begin
                errors++; $display("FAIL stray_w%0d got v=%b %h l=%b want 1 %h", i, m_valid, m_data, m_last, e3[i]);
            end
            tick();
        end
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL stray_end got v=%b rdy=%b want 0 1", m_valid, s_ready);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n && s_ready && m_valid) begin
            errors++;
            $display("FAIL inv_ready_valid got both high want exclusive");
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d1 = {32'h00080000, 32'h00070000, 32'h00060000, 32'h00050000,
              32'h00040000, 32'h00030000, 32'h00020000, 32'h00010000};
        e1 = {32'h00320000, 32'h002B0000, 32'h00160000, 32'h00130000};
        d2 = {32'h00030000, 32'h00040000, 32'h00010000, 32'h00020000,
              32'h00020000, 32'hFFFF0000, 32'h00008000, 32'h00010000};
        e2 = {32'h00050000, 32'h00060000, 32'h00028000, 32'h00040000};
        d3 = {32'h00080000, 32'h00070000, 32'h00060000, 32'h00050000,
              32'h00020000, 32'h00000000, 32'h00000000, 32'h00020000};
        e3 = {32'h00100000, 32'h000E0000, 32'h000C0000, 32'h000A0000};
        test_reset();
        test_nominal();
        test_backpressure();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_stray_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
